// File: rtl/ccx_trace_buffer_if.sv
// ============================================================================
//  Module      : ccx_trace_buffer_if
//  Description : Trace-capture and read-port bundle for ccx_trace_buffer.
//                rd_tstamp exists only when CCX_TRACE_TSTAMP_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ccx_trace_buffer_if;
    logic        trs_valid;
    logic [31:0] trs_instr;
    logic [63:0] trs_pc;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_instr;
    logic [63:0] rd_pc;
`ifdef CCX_TRACE_TSTAMP_EN
    logic [31:0] rd_tstamp;

    modport slave  (input  trs_valid, trs_instr, trs_pc, rd_ready,
                    output rd_valid, rd_instr, rd_pc, rd_tstamp);
    modport master (output trs_valid, trs_instr, trs_pc, rd_ready,
                    input  rd_valid, rd_instr, rd_pc, rd_tstamp);
`else
    modport slave  (input  trs_valid, trs_instr, trs_pc, rd_ready,
                    output rd_valid, rd_instr, rd_pc);
    modport master (output trs_valid, trs_instr, trs_pc, rd_ready,
                    input  rd_valid, rd_instr, rd_pc);
`endif
endinterface

`default_nettype wire

// File: rtl/ccx_trace_buffer.sv
// ============================================================================
//  Module      : ccx_trace_buffer
//  Description : Show-ahead capture FIFO for the retired-instruction trace,
//                with drop-new or overwrite-oldest overflow handling.
//                Optional timestamping: define CCX_TRACE_TSTAMP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccx_trace_buffer #(
    parameter int DEPTH     = 16,
    parameter bit WRAP_MODE = 1'b0,
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  wire logic          f_clk,
    input  wire logic          g_reset,
    input  wire logic          trc_en,
    input  wire logic          trc_clear,
    ccx_trace_buffer_if.slave  trs,
    output logic [CW-1:0]      count,
    output logic               overflow,
    output logic [15:0]        drop_count
);

    localparam int AW = $clog2(DEPTH);
`ifdef CCX_TRACE_TSTAMP_EN
    localparam int EW = 128;
`else
    localparam int EW = 96;
`endif

    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     drop_q, drop_d;

    logic            w_push, w_pop, w_full, w_write, w_lost, w_advance;
    logic [EW-1:0]   w_entry;
    logic [EW-1:0]   w_head;

`ifdef CCX_TRACE_TSTAMP_EN
    logic [31:0]     tstamp_q;

    // Free-running; only g_reset clears it, trc_clear deliberately does not.
    always_ff @(posedge f_clk) begin
        if (g_reset) tstamp_q <= 32'd0;
        else         tstamp_q <= tstamp_q + 32'd1;
    end

    assign w_entry       = {tstamp_q, trs.trs_pc, trs.trs_instr};
    assign trs.rd_tstamp = w_head[127:96];
`else
    assign w_entry = {trs.trs_pc, trs.trs_instr};
`endif

    assign w_push = trc_en & trs.trs_valid;
    assign w_pop  = trs.rd_valid & trs.rd_ready;
    assign w_full = (count_q == CW'(DEPTH));

    // A full FIFO still accepts the push when a pop frees a slot or in wrap mode.
    assign w_write   = w_push & (~w_full | w_pop | WRAP_MODE);
    assign w_lost    = w_push & w_full & ~w_pop;
    assign w_advance = w_pop | (w_lost & WRAP_MODE);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (trc_clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_d     = 16'd0;
        end else begin
            if (w_write)   wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_advance) rd_ptr_d = rd_ptr_q + 1'b1;
            if (w_write && !w_advance)      count_d = count_q + 1'b1;
            else if (!w_write && w_advance) count_d = count_q - 1'b1;
            if (w_lost) begin
                overflow_d = 1'b1;
                if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            end
        end
    end

    always_ff @(posedge f_clk) begin
        if (g_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= 16'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge f_clk) begin
        if (!g_reset && !trc_clear && w_write) mem_q[wr_ptr_q] <= w_entry;
    end

    assign w_head       = mem_q[rd_ptr_q];
    assign trs.rd_valid = (count_q != '0);
    assign trs.rd_instr = w_head[31:0];
    assign trs.rd_pc    = w_head[95:32];

    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_ccx_trace_buffer.sv
// ============================================================================
//  Module      : tb_ccx_trace_buffer
//  Description : Directed bench; u0 runs drop-new, u1 runs overwrite-oldest.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ccx_trace_buffer;

    logic        f_clk = 1'b0;
    logic        g_reset, trc_en, trc_clear, trs_valid, rdy0, rdy1;
    logic [31:0] trs_instr;
    logic [63:0] trs_pc;
    logic [4:0]  count0, count1;
    logic        ovf0, ovf1;
    logic [15:0] drop0, drop1;
    int          total = 0;
    int          bad   = 0;

    always #5 f_clk = ~f_clk;

    ccx_trace_buffer_if if0();
    ccx_trace_buffer_if if1();

    assign if0.trs_valid = trs_valid;
    assign if0.trs_instr = trs_instr;
    assign if0.trs_pc    = trs_pc;
    assign if0.rd_ready  = rdy0;
    assign if1.trs_valid = trs_valid;
    assign if1.trs_instr = trs_instr;
    assign if1.trs_pc    = trs_pc;
    assign if1.rd_ready  = rdy1;

    ccx_trace_buffer #(.DEPTH(16), .WRAP_MODE(1'b0)) u0 (
        .f_clk(f_clk), .g_reset(g_reset), .trc_en(trc_en), .trc_clear(trc_clear),
        .trs(if0), .count(count0), .overflow(ovf0), .drop_count(drop0));

    ccx_trace_buffer #(.DEPTH(16), .WRAP_MODE(1'b1)) u1 (
        .f_clk(f_clk), .g_reset(g_reset), .trc_en(trc_en), .trc_clear(trc_clear),
        .trs(if1), .count(count1), .overflow(ovf1), .drop_count(drop1));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge f_clk);
        #1;
    endtask

    function automatic logic [63:0] pc_of(input int i);
        return 64'h1000 + 64'(i) * 64'd4;
    endfunction

    initial begin
        g_reset = 1'b1; trc_en = 1'b1; trc_clear = 1'b0; trs_valid = 1'b0;
        rdy0 = 1'b0; rdy1 = 1'b0; trs_instr = '0; trs_pc = '0;
        tick(); tick();
        g_reset = 1'b0;
        check("rst_valid0", 64'(if0.rd_valid), 64'd0);
        check("rst_count0", 64'(count0), 64'd0);
        check("rst_ovf0",   64'(ovf0), 64'd0);
        check("rst_drop1",  64'(drop1), 64'd0);

        // single push then pop
        trs_valid = 1'b1; trs_pc = 64'h100; trs_instr = 32'h0000_0013;
        tick();
        trs_valid = 1'b0;
        check("t1_valid", 64'(if0.rd_valid), 64'd1);
        check("t1_pc",    if0.rd_pc, 64'h100);
        check("t1_instr", 64'(if0.rd_instr), 64'h13);
        check("t1_count", 64'(count0), 64'd1);
        rdy0 = 1'b1; rdy1 = 1'b1;
        tick();
        rdy0 = 1'b0; rdy1 = 1'b0;
        check("t1_count_after_pop", 64'(count0), 64'd0);
        check("t1_valid_after_pop", 64'(if1.rd_valid), 64'd0);

        // trc_en low ignores trs_valid
        trc_en = 1'b0; trs_valid = 1'b1;
        tick();
        check("en_off_count", 64'(count0), 64'd0);
        trc_en = 1'b1;

        // 18 pushes with no reads
        for (int i = 0; i < 18; i++) begin
            trs_pc = pc_of(i); trs_instr = 32'hA000_0000 + 32'(i);
            tick();
        end
        trs_valid = 1'b0;
        check("t2_count", 64'(count0), 64'd16);
        check("t2_ovf",   64'(ovf0), 64'd1);
        check("t2_drop",  64'(drop0), 64'd2);
        check("t2_head",  if0.rd_pc, pc_of(0));
        check("t3_count", 64'(count1), 64'd16);
        check("t3_ovf",   64'(ovf1), 64'd1);
        check("t3_drop",  64'(drop1), 64'd2);
        check("t3_head",  if1.rd_pc, pc_of(2));
        check("t3_instr", 64'(if1.rd_instr), 64'hA000_0002);

        // full with simultaneous push and pop
        trs_valid = 1'b1; trs_pc = pc_of(18); trs_instr = 32'hA000_0012;
        rdy0 = 1'b1; rdy1 = 1'b1;
        tick();
        trs_valid = 1'b0;
        check("t4_count0", 64'(count0), 64'd16);
        check("t4_drop0",  64'(drop0), 64'd2);
        check("t4_count1", 64'(count1), 64'd16);
        check("t4_drop1",  64'(drop1), 64'd2);

        // drain both; entry 18 must come last
        for (int k = 0; k < 16; k++) begin
            check("drain_pc0", if0.rd_pc, (k < 15) ? pc_of(k + 1) : pc_of(18));
            check("drain_pc1", if1.rd_pc, (k < 15) ? pc_of(k + 3) : pc_of(18));
            tick();
        end
        rdy0 = 1'b0; rdy1 = 1'b0;
        check("drain_count0", 64'(count0), 64'd0);
        check("drain_valid1", 64'(if1.rd_valid), 64'd0);

        // clear beats a simultaneous push
        trs_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            trs_pc = pc_of(i); tick();
        end
        check("t5_count", 64'(count0), 64'd5);
        check("t5_ovf",   64'(ovf0), 64'd1);
        trc_clear = 1'b1;
        tick();
        trc_clear = 1'b0; trs_valid = 1'b0;
        check("t5_clr_count", 64'(count0), 64'd0);
        check("t5_clr_valid", 64'(if0.rd_valid), 64'd0);
        check("t5_clr_ovf",   64'(ovf0), 64'd0);
        check("t5_clr_drop",  64'(drop0), 64'd0);
        check("t5_clr_ovf1",  64'(ovf1), 64'd0);

`ifdef CCX_TRACE_TSTAMP_EN
        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        repeat (10) tick();
        trs_valid = 1'b1; trs_pc = pc_of(40);
        tick();
        trs_valid = 1'b0;
        tick(); tick();
        trs_valid = 1'b1; trs_pc = pc_of(41);
        tick();
        trs_valid = 1'b0;
        check("t6_ts_first", 64'(if0.rd_tstamp), 64'd10);
        rdy0 = 1'b1;
        tick();
        rdy0 = 1'b0;
        check("t6_ts_second", 64'(if0.rd_tstamp), 64'd13);
        check("t6_pc_second", if0.rd_pc, pc_of(41));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
